reset_sequencer: RTL
====================

RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, cycles the synced button level must stay constant before it is accepted.
REQ-002 Parameter PLL_RESET_CYCLES, default 64, width of the pll_areset pulse in clk cycles.
REQ-003 Parameter LOCK_TIMEOUT_CYCLES, default 500000, maximum wait for lock before the PLL is reset again.
REQ-004 Parameter LOCK_STABLE_CYCLES, default 4096, cycles lock must hold continuously before core reset is released.
REQ-005 Parameter COUNTER_WIDTH, default 20, width of each cycle counter; SHALL hold the largest of the cycle parameters minus 1.
REQ-006 clk  input  1  free-running board oscillator clock; all logic is on posedge clk.
REQ-007 reset_n  input  1  reset; one clock, synchronous and active-low.
REQ-008 pb_n  input  1  asynchronous push button, low = pressed.
REQ-009 pll_locked  input  1  asynchronous PLL lock indicator.
REQ-010 pll_areset  output  1  active-high PLL reset.
REQ-011 core_reset  output  1  active-high SoC reset; the SoC synchronizes it into its own clock domain.
REQ-012 state  output  2  current FSM state, for the LEDs.
REQ-013 restart_count  output  8  saturating count of automatic PLL restarts.

Function
REQ-014 pb_n and pll_locked SHALL each pass through a 2-flop synchronizer (pb_s, lock_s) before any use.
REQ-015 Debounce: counter clears while pb_s equals the stable level. Otherwise it increments each cycle, and at DEBOUNCE_CYCLES-1 the stable level takes pb_s and the counter clears.
REQ-016 A press event SHALL be a single-cycle pulse when the stable level goes from 1 to 0; a release SHALL produce no event.
REQ-017 The FSM states SHALL be PLL_RESET=0, WAIT_LOCK=1, STRETCH=2 and RUN=3, all sharing one cycle counter cnt.
REQ-018 PLL_RESET: cnt increments each cycle; at cnt==PLL_RESET_CYCLES-1 go to WAIT_LOCK with cnt=0.
REQ-019 WAIT_LOCK: if lock_s, go to STRETCH with cnt=0. Else at cnt==LOCK_TIMEOUT_CYCLES-1, go to PLL_RESET with cnt=0 and restart_count incremented.
REQ-020 STRETCH: if !lock_s, go to WAIT_LOCK with cnt=0. Else at cnt==LOCK_STABLE_CYCLES-1, go to RUN.
REQ-021 RUN: if !lock_s, go to PLL_RESET with cnt=0 and restart_count incremented.
REQ-022 A press event SHALL force PLL_RESET with cnt=0 from any state, overriding every other transition, and SHALL NOT increment restart_count.
REQ-023 Press event in the same cycle as lock loss or timeout: PLL_RESET, restart_count unchanged.
REQ-024 Press event while already in PLL_RESET SHALL restart the pulse (cnt=0), lengthening it.
REQ-025 pll_areset SHALL be registered as (next state == PLL_RESET), so it is high exactly PLL_RESET_CYCLES cycles per uninterrupted visit.
REQ-026 core_reset SHALL be registered as (next state != RUN), so it falls on the first RUN cycle and rises on the cycle the FSM leaves RUN.
REQ-027 restart_count SHALL saturate at 255 and never wrap.
REQ-028 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-029 While reset_n is low at posedge clk, the block SHALL hold these values:
- state=PLL_RESET, cnt=0, pll_areset=1, core_reset=1, restart_count=0
- pb sync flops=1, stable button level=1, debounce counter=0
- lock sync flops=0
REQ-030 reset_n asserted mid-operation SHALL apply REQ-029 on the next edge; the PLL_RESET pulse then starts afresh.

Structure
REQ-031 The shared package reset_seq_pkg SHALL hold the state encoding constants and the default parameter values.
REQ-032 Debounce (the REQ-014 synchronizer, REQ-015 and REQ-016) SHALL be one sub-module, debounce, instantiated once for pb_n.
REQ-033 The lock synchronizer and FSM SHALL live in reset_sequencer itself.

Verification (DEBOUNCE_CYCLES=4, PLL_RESET_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, LOCK_STABLE_CYCLES=16)
REQ-034 Lock already high at reset release -> pll_areset high 8 cycles; core_reset falls at the first RUN edge; restart_count=0.
REQ-035 pll_locked never rises -> WAIT_LOCK for 32 cycles, then PLL_RESET again; restart_count steps 1,2,3,... and stops at 255.
REQ-036 Lock glitches low for 3 cycles during STRETCH -> back to WAIT_LOCK, then a full 16-cycle STRETCH, and core_reset stays high throughout.
REQ-037 Lock drops in RUN -> core_reset high and pll_areset high for 8 cycles; restart_count +1.
REQ-038 Button bounce (pb_n low 2 cycles, then a steady 10-cycle low) -> exactly one press event, PLL_RESET entered once, restart_count unchanged.
REQ-039 reset_n pulsed low for 1 cycle in RUN -> all REQ-029 values on the next edge, then the normal sequence resumes.

Source files
------------

// File: rtl/reset_seq_pkg.sv
// reset_seq_pkg: shared state encoding and default timing for the board reset
// sequencer. The state codes are driven straight onto the LED port, so their
// values are fixed.
package reset_seq_pkg;

  localparam int unsigned DEBOUNCE_CYCLES_DEF     = 1000000;
  localparam int unsigned PLL_RESET_CYCLES_DEF    = 64;
  localparam int unsigned LOCK_TIMEOUT_CYCLES_DEF = 500000;
  localparam int unsigned LOCK_STABLE_CYCLES_DEF  = 4096;
  localparam int unsigned COUNTER_WIDTH_DEF       = 20;

  typedef enum logic [1:0] {
    PLL_RESET = 2'd0,
    WAIT_LOCK = 2'd1,
    STRETCH   = 2'd2,
    RUN       = 2'd3
  } state_e;

endpackage

// File: rtl/reset_sequencer_debounce.sv
// debounce: synchronizes an active-low push button and accepts a new level
// only after it has been held for CYCLES clocks. Emits a one-cycle press pulse
// when the accepted level goes from released (1) to pressed (0).
//   clk       in   system clock
//   reset_n   in   synchronous active-low reset
//   btn_n_i   in   asynchronous button, low = pressed
//   press_o   out  registered single-cycle press event
module debounce
  import reset_seq_pkg::*;
#(
  parameter int unsigned CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned WIDTH  = COUNTER_WIDTH_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_n_i,
  output logic press_o
);

  localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(CYCLES - 1);

  logic [1:0]       sync_q;
  logic             stable_q;
  logic [WIDTH-1:0] cnt_q;
  logic             press_q;
  logic             btn_s;

  assign btn_s   = sync_q[1];
  assign press_o = press_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_q   <= 2'b11;
      stable_q <= 1'b1;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_n_i};
      press_q <= 1'b0;
      if (btn_s == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        stable_q <= btn_s;
        cnt_q    <= '0;
        // Only the 1 -> 0 transition of the accepted level is an event.
        press_q  <= ~btn_s;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: holds the PLL in reset, waits for a stable lock, then
// releases the SoC reset. Lost lock or a lock timeout restarts the PLL; a
// debounced button press forces a restart from any state.
//   clk            in   free-running board oscillator
//   reset_n        in   synchronous active-low reset
//   pb_n           in   asynchronous push button, low = pressed
//   pll_locked     in   asynchronous PLL lock indicator
//   pll_areset     out  active-high PLL reset (registered)
//   core_reset     out  active-high SoC reset (registered)
//   state          out  current FSM state for LEDs
//   restart_count  out  saturating count of automatic PLL restarts
//
// state      | meaning
// PLL_RESET  | pll_areset asserted for PLL_RESET_CYCLES
// WAIT_LOCK  | waiting for lock, bounded by LOCK_TIMEOUT_CYCLES
// STRETCH    | lock must hold LOCK_STABLE_CYCLES before release
// RUN        | core reset released, lock monitored
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES     = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned PLL_RESET_CYCLES    = PLL_RESET_CYCLES_DEF,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = LOCK_TIMEOUT_CYCLES_DEF,
  parameter int unsigned LOCK_STABLE_CYCLES  = LOCK_STABLE_CYCLES_DEF,
  parameter int unsigned COUNTER_WIDTH       = COUNTER_WIDTH_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pb_n,
  input  logic       pll_locked,
  output logic       pll_areset,
  output logic       core_reset,
  output logic [1:0] state,
  output logic [7:0] restart_count
);

  localparam logic [COUNTER_WIDTH-1:0] PLL_LAST = COUNTER_WIDTH'(PLL_RESET_CYCLES - 1);
  localparam logic [COUNTER_WIDTH-1:0] TO_LAST  = COUNTER_WIDTH'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [COUNTER_WIDTH-1:0] STB_LAST = COUNTER_WIDTH'(LOCK_STABLE_CYCLES - 1);

  logic [1:0]               lock_sync_q;
  logic                     lock_s;
  logic                     press;
  state_e                   state_q, state_d;
  logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
  logic [7:0]               rc_q, rc_d;
  logic                     bump;
  logic                     pll_areset_q;
  logic                     core_reset_q;

  debounce #(
    .CYCLES (DEBOUNCE_CYCLES),
    .WIDTH  (COUNTER_WIDTH)
  ) u_debounce (
    .clk     (clk),
    .reset_n (reset_n),
    .btn_n_i (pb_n),
    .press_o (press)
  );

  assign lock_s = lock_sync_q[1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bump    = 1'b0;
    // A press wins over everything, including a simultaneous timeout or lock
    // loss, and is never counted as an automatic restart.
    if (press) begin
      state_d = PLL_RESET;
      cnt_d   = '0;
    end else begin
      case (state_q)
        PLL_RESET: begin
          if (cnt_q == PLL_LAST) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
          end
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            state_d = STRETCH;
            cnt_d   = '0;
          end else if (cnt_q == TO_LAST) begin
            state_d = PLL_RESET;
            cnt_d   = '0;
            bump    = 1'b1;
          end
        end
        STRETCH: begin
          if (!lock_s) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == STB_LAST) begin
            state_d = RUN;
            cnt_d   = '0;
          end
        end
        RUN: begin
          cnt_d = '0;
          if (!lock_s) begin
            state_d = PLL_RESET;
            bump    = 1'b1;
          end
        end
        default: begin
          state_d = PLL_RESET;
          cnt_d   = '0;
        end
      endcase
    end
    rc_d = (bump && rc_q != 8'hFF) ? rc_q + 8'd1 : rc_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lock_sync_q  <= 2'b00;
      state_q      <= PLL_RESET;
      cnt_q        <= '0;
      rc_q         <= 8'd0;
      pll_areset_q <= 1'b1;
      core_reset_q <= 1'b1;
    end else begin
      lock_sync_q  <= {lock_sync_q[0], pll_locked};
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rc_q         <= rc_d;
      pll_areset_q <= (state_d == PLL_RESET);
      core_reset_q <= (state_d != RUN);
    end
  end

  assign pll_areset    = pll_areset_q;
  assign core_reset    = core_reset_q;
  assign state         = state_q;
  assign restart_count = rc_q;

endmodule
